play_engine: RTL and testbench
==============================

Name: play_engine

Overview:
- Responder side of the controller's play command interface.
- Accepts play_start, play_select, play_pause and play_stop, and returns play_done.
- Streams a recorded clip out of sample memory, one 16-bit sample per DAC request, starting at address 0.
- Sits between the control core, the memory read port (SRAM/SDRAM arbiter) and the audio DAC serializer.

Parameters:
ADDR_W, 23, width of play_select and memory address
DATA_W, 16, sample width
UNDER_W, 8, width of saturating underrun counter

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
play_start  in  1  play request; level, may be held high for many cycles
play_select  in  ADDR_W  clip length in samples, latched at start
play_pause  in  1  level; freeze playback while high
play_stop  in  1  level; abort playback
play_done  out  1  one-cycle pulse when playback ends (completed or stopped)
rd_req  out  1  memory read request, held until rd_ack
rd_addr  out  ADDR_W  read address, stable while rd_req high
rd_ack  in  1  one-cycle read acknowledge; rd_data valid same cycle
rd_data  in  DATA_W  read data
dac_req  in  1  one-cycle pulse per DAC sample slot
dac_data  out  DATA_W  sample to DAC, registered
underrun_cnt  out  UNDER_W  saturating count of dac_req with no buffered sample
busy  out  1  high in any state except IDLE

Behaviour:
- Reset state: IDLE. All outputs are 0: play_done, rd_req, rd_addr, dac_data, underrun_cnt, busy. Internal address, length and buffer-valid flag are also 0.
- Reset mid-operation: rd_req drops in the next cycle regardless of handshake. The arbiter discards any outstanding read.
- States: IDLE, FETCH, HOLD, DONE.
- IDLE:
  - On play_start=1, latch len=play_select and set addr=0.
  - Clear underrun_cnt.
  - If len==0, go to DONE (no memory reads). Otherwise go to FETCH.
- FETCH:
  - rd_req=1 with rd_addr=addr.
  - On rd_ack: buffer<=rd_data, buf_valid<=1, go to HOLD. rd_req is low in the cycle after rd_ack.
  - rd_req is never withdrawn before rd_ack, even on stop or pause.
- HOLD:
  - On dac_req with play_pause=0: dac_data<=buffer, visible next cycle; buf_valid<=0.
  - If addr==len-1, go to DONE. Otherwise addr<=addr+1 and go to FETCH.
- Underrun: dac_req in FETCH (buffer empty, not paused) gives dac_data<=0 and underrun_cnt+1, saturating at all-ones. The address does not advance.
- Pause:
  - While play_pause=1, dac_req gives dac_data<=0. No buffer consumption, no underrun count.
  - An in-flight read completes normally into the buffer. No new rd_req is issued while paused in HOLD.
  - On release, playback resumes at the same addr.
- Stop:
  - play_stop=1 in HOLD goes to DONE next cycle.
  - In FETCH, stop is registered; transition to DONE occurs the cycle after rd_ack, and the fetched data is discarded.
- Priority, same cycle: stop > pause > dac_req. An end-of-clip dac_req with stop outputs the sample and goes to DONE (single play_done).
- DONE:
  - play_done=1 for exactly the cycle of entry.
  - dac_data<=0.
  - Stay in DONE until play_start=0, then go to IDLE. A held-high play_start does not retrigger.
- play_start, play_select, pause and stop changes are ignored outside their defined states. play_select is not re-sampled during playback.
- Address arithmetic is ADDR_W unsigned. Maximum clip length is 2^ADDR_W-1; addr never wraps.
- busy = (state != IDLE).

Test Plan:
- Reset with len=4, rd_ack 2 cycles after rd_req, dac_req every 10 cycles, rd_data=addr+0x100 -> rd_addr 0,1,2,3; dac_data 0x100..0x103; play_done pulses once, one cycle after the 4th dac_req; busy stays high until play_start drops.
- play_select=0 with play_start held 20 cycles -> no rd_req, play_done pulse exactly once, IDLE only after play_start=0.
- rd_ack delayed 30 cycles while dac_req every 10 cycles, len=2 -> underrun_cnt=3 at first sample, dac_data=0 on those slots; data still in order.
- play_pause asserted mid-read at addr 5 for 50 cycles -> read completes, no further rd_req, dac_data=0, underrun_cnt unchanged; resume outputs sample 5 then 6.
- play_stop pulsed while rd_req high -> rd_req held until rd_ack, DONE the next cycle, play_done one pulse, fetched sample never on dac_data.
- i_rst asserted in HOLD -> next cycle all outputs 0, state IDLE; with play_start still high, a new playback starts from addr 0 after reset release.

Source files
------------

// File: rtl/play_engine.sv
// Play command responder: streams a clip from sample memory to the DAC,
// one sample per DAC slot, with pause, stop and underrun accounting.
module play_engine #(
  parameter int unsigned ADDR_W  = 23,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned UNDER_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               play_start,
  input  logic [ADDR_W-1:0]  play_select,
  input  logic               play_pause,
  input  logic               play_stop,
  output logic               play_done,
  output logic               rd_req,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_ack,
  input  logic [DATA_W-1:0]  rd_data,
  input  logic               dac_req,
  output logic [DATA_W-1:0]  dac_data,
  output logic [UNDER_W-1:0] underrun_cnt,
  output logic               busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_len;
  logic [DATA_W-1:0]  r_buf;
  logic [DATA_W-1:0]  r_dac;
  logic [UNDER_W-1:0] r_under;
  logic               r_buf_vld;
  logic               r_stop_pend;
  logic               r_done;

  logic w_last;
  logic w_consume;
  logic w_under_max;

  assign w_last      = (r_addr == r_len - ADDR_W'(1));
  assign w_under_max = &r_under;
  // A stop in the same slot as the final sample still lets that sample out.
  assign w_consume   = dac_req && !play_pause && r_buf_vld && (!play_stop || w_last);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_buf       <= '0;
      r_dac       <= '0;
      r_under     <= '0;
      r_buf_vld   <= 1'b0;
      r_stop_pend <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dac_req) r_dac <= '0;
          if (play_start) begin
            r_len       <= play_select;
            r_addr      <= '0;
            r_under     <= '0;
            r_buf_vld   <= 1'b0;
            r_stop_pend <= 1'b0;
            if (play_select == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (play_stop) r_stop_pend <= 1'b1;
          if (dac_req) begin
            r_dac <= '0;
            if (!play_pause && !play_stop && !r_stop_pend && !w_under_max)
              r_under <= r_under + UNDER_W'(1);
          end
          // The read is never abandoned; a pending stop only discards its data.
          if (rd_ack) begin
            if (r_stop_pend || play_stop) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_buf     <= rd_data;
              r_buf_vld <= 1'b1;
              r_state   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_consume) begin
            r_dac     <= r_buf;
            r_buf_vld <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_addr  <= r_addr + ADDR_W'(1);
              r_state <= S_FETCH;
            end
          end else begin
            if (dac_req) r_dac <= '0;
            if (play_stop) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_dac       <= '0;
          r_buf_vld   <= 1'b0;
          r_stop_pend <= 1'b0;
          if (!play_start) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign play_done    = r_done;
  assign rd_req       = (r_state == S_FETCH);
  assign rd_addr      = r_addr;
  assign dac_data     = r_dac;
  assign underrun_cnt = r_under;
  assign busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_play_engine.sv
// Bench for play_engine: table of playback runs against a memory responder
// and a DAC scoreboard, plus a reset-during-playback sequence.
module tb_play_engine;
  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 16;
  localparam int UNDER_W = 8;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               play_start;
  logic [ADDR_W-1:0]  play_select;
  logic               play_pause;
  logic               play_stop;
  logic               play_done;
  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_ack;
  logic [DATA_W-1:0]  rd_data;
  logic               dac_req;
  logic [DATA_W-1:0]  dac_data;
  logic [UNDER_W-1:0] underrun_cnt;
  logic               busy;

  play_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .UNDER_W(UNDER_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .play_start(play_start), .play_select(play_select),
    .play_pause(play_pause), .play_stop(play_stop), .play_done(play_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .dac_req(dac_req), .dac_data(dac_data), .underrun_cnt(underrun_cnt), .busy(busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int len;
    int ack;
    int per;
    int exp_under;
    int exp_reads;
    int pause_addr;
    int stop_addr;
  } vec_t;

  int nchk = 0;
  int nfail = 0;
  int s, per, ack_dly, m_wait, acks, consumed, len_m;
  int done_cnt, done_step, last_cons, ack_step;
  int pause_left, pause_addr, stop_addr, under_at_pause;
  bit avail, playing, chk_pend, pause_hit, stop_hit;
  logic [15:0] avail_val;
  logic [15:0] dq[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (step %0d)", nm, act, exp, s);
    end
  endtask

  // One cycle: sample outputs at the negedge, then drive the next inputs.
  task automatic step();
    logic [15:0] e;
    if (chk_pend) begin
      e = dq.pop_front();
      chk("dac_data", dac_data, e);
      chk_pend = 0;
    end
    if (play_done) begin
      done_cnt++;
      done_step = s;
    end
    play_stop = 0;
    if (pause_left > 0) begin
      pause_left--;
      if (pause_left == 0) begin
        play_pause = 0;
        chk("reads_at_resume", acks, pause_addr + 1);
        chk("under_at_resume", underrun_cnt, under_at_pause);
      end
    end
    if (rd_req && !pause_hit && int'(rd_addr) == pause_addr) begin
      pause_hit = 1; play_pause = 1; pause_left = 50; under_at_pause = underrun_cnt;
    end
    if (rd_req && !stop_hit && int'(rd_addr) == stop_addr) begin
      stop_hit = 1; play_stop = 1; playing = 0;
    end
    dac_req = (per > 0) && (s > 0) && (s % per == 0);
    if (dac_req) begin
      if (playing && avail && !play_pause) begin
        dq.push_back(avail_val);
        avail = 0;
        consumed++;
        last_cons = s;
        if (consumed == len_m) playing = 0;
      end else begin
        dq.push_back(16'h0);
      end
      chk_pend = 1;
    end
    rd_ack = 0;
    if (rd_req) begin
      if (m_wait == ack_dly) begin
        rd_ack = 1;
        rd_data = rd_addr[15:0] + 16'h100;
        chk("rd_addr", rd_addr, acks);
        acks++;
        ack_step = s;
        m_wait = 0;
        if (playing) begin avail = 1; avail_val = rd_data; end
      end else begin
        m_wait++;
      end
    end
    s++;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic init_model(input int len, input int ad, input int p, input int pa, input int sa);
    len_m = len; ack_dly = ad; per = p; pause_addr = pa; stop_addr = sa;
    playing = (len != 0); avail = 0; consumed = 0; acks = 0; m_wait = 0;
    done_cnt = 0; done_step = -1; last_cons = -1; ack_step = -1;
    pause_hit = 0; stop_hit = 0; pause_left = 0; s = 0;
  endtask

  task automatic run(input vec_t v);
    int g;
    init_model(v.len, v.ack, v.per, v.pause_addr, v.stop_addr);
    play_select = ADDR_W'(v.len);
    play_start = 1;
    g = 0;
    while (done_cnt == 0 && g < 3000) begin step(); g++; end
    chk("play_done_seen", done_cnt, 1);
    if (v.stop_addr >= 0)  chk("done_after_stop_ack", done_step, ack_step + 1);
    else if (v.len == 0)   chk("done_len0", done_step, 1);
    else                   chk("done_after_last", done_step, last_cons + 1);
    repeat (20) step();
    chk("busy_while_start_held", busy, 1);
    chk("single_done", done_cnt, 1);
    play_start = 0;
    step();
    step();
    chk("busy_idle", busy, 0);
    chk("reads", acks, v.exp_reads);
    chk("underrun_cnt", underrun_cnt, v.exp_under);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[8];
    int g;
    tv[0] = '{4,   2,  10,   0, 4, -1, -1};
    tv[1] = '{0,   2,  10,   0, 0, -1, -1};
    tv[2] = '{2,  30,  10,   6, 2, -1, -1};
    tv[3] = '{3,   5,   4,   3, 3, -1, -1};
    tv[4] = '{1,   0,   3,   0, 1, -1, -1};
    tv[5] = '{8,   2,  10,   0, 8,  5, -1};
    tv[6] = '{8,   5,  10,   0, 3, -1,  2};
    tv[7] = '{1, 300,   1, 255, 1, -1, -1};

    i_rst = 1; play_start = 0; play_select = '0; play_pause = 0; play_stop = 0;
    rd_ack = 0; rd_data = '0; dac_req = 0; chk_pend = 0; s = 0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_play_done", play_done, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_dac_data", dac_data, 0);
    chk("rst_underrun", underrun_cnt, 0);
    i_rst = 0;

    for (int i = 0; i < 8; i++) run(tv[i]);

    // Reset while holding sample 1: everything clears, held start replays from 0.
    init_model(4, 2, 10, -1, -1);
    play_select = ADDR_W'(4);
    play_start = 1;
    g = 0;
    while (acks < 2 && g < 200) begin step(); g++; end
    chk("hold_busy", busy, 1);
    chk("hold_rd_req", rd_req, 0);
    chk("hold_rd_addr", rd_addr, 1);
    chk("hold_dac_data", dac_data, 16'h100);
    per = 0;
    i_rst = 1;
    step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_req", rd_req, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_dac_data", dac_data, 0);
    chk("mid_rst_play_done", play_done, 0);
    chk("mid_rst_underrun", underrun_cnt, 0);
    i_rst = 0;
    acks = 0; m_wait = 0;
    step();
    chk("restart_rd_req", rd_req, 1);
    chk("restart_rd_addr", rd_addr, 0);
    chk("restart_busy", busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
